// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It drives the synchronous program memory address,
// pairs each returned word with its PC for the decoder, and raises the
// decoder flush on a taken jump. The flush is held for FLUSH_CYCLES cycles
// after the jump cycle while the redirected fetch refills the pipeline.
//
// Optional feature macro: FETCH_STALL_EN
//   When defined, this adds the in_stall port and a one-word hold register.
//   The register keeps the presented word stable while the decoder stalls.
//
// Ports:
//   clock           sole clock, rising edge
//   reset           synchronous, active-low reset
//   in_jump         redirect request from execute (combinationally flushes)
//   in_jump_target  redirect address, valid with in_jump
//   in_stall        decoder back-pressure (FETCH_STALL_EN only)
//   in_pmem_data    PMEM read data for the address driven last cycle
//   out_pmem_addr   PMEM read address (= pc_fetch)
//   out_instr       instruction word to decoder, 0 (NOP) when not valid
//   out_pc          address of the word on out_instr
//   out_flush       flush to decoder
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned PMEM_ADDR_WIDTH = 12,
  parameter int unsigned PMEM_WORD_WIDTH = 16,
  parameter int unsigned PC_WIDTH        = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned FLUSH_CYCLES    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_jump,
  input  logic [PC_WIDTH-1:0]        in_jump_target,
`ifdef FETCH_STALL_EN
  input  logic                       in_stall,
`endif
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_data,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_flush
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0]          FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_fetch_q, pc_fetch_d;
  logic [PC_WIDTH-1:0] pc_issued_q, pc_issued_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;

  // Word presented in RUN: normally straight from memory. While a stall is
  // pending, it comes from the hold register because the memory has already
  // moved on to the next address.
  logic [PMEM_WORD_WIDTH-1:0] run_word;

`ifdef FETCH_STALL_EN
  logic [PMEM_WORD_WIDTH-1:0] hold_q, hold_d;
  logic                       hold_vld_q, hold_vld_d;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      pc_fetch_q  <= RESET_PC;
      pc_issued_q <= RESET_PC;
      flush_cnt_q <= '0;
`ifdef FETCH_STALL_EN
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_fetch_q  <= pc_fetch_d;
      pc_issued_q <= pc_issued_d;
      flush_cnt_q <= flush_cnt_d;
`ifdef FETCH_STALL_EN
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_fetch_d  = pc_fetch_q;
    pc_issued_d = pc_issued_q;
    flush_cnt_d = flush_cnt_q;
    out_instr   = '0;
    run_word    = in_pmem_data;
`ifdef FETCH_STALL_EN
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    if (hold_vld_q) begin
      run_word = hold_q;
    end
`endif

    if (in_jump) begin
      // Redirect wins over everything except reset, including a stall.
      pc_fetch_d  = in_jump_target;
      flush_cnt_d = FLUSH_INIT;
      state_d     = ST_FLUSH;
`ifdef FETCH_STALL_EN
      hold_vld_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          pc_issued_d = pc_fetch_q;
          pc_fetch_d  = pc_fetch_q + PC_ONE;
          state_d     = ST_RUN;
        end
        ST_RUN: begin
          out_instr = run_word;
`ifdef FETCH_STALL_EN
          if (in_stall) begin
            // Freeze both PCs; capture the word on the first stall cycle so
            // that later cycles still show it after memory moves on.
            hold_d     = run_word;
            hold_vld_d = 1'b1;
          end else begin
            hold_vld_d  = 1'b0;
            pc_issued_d = pc_fetch_q;
            pc_fetch_d  = pc_fetch_q + PC_ONE;
          end
`else
          pc_issued_d = pc_fetch_q;
          pc_fetch_d  = pc_fetch_q + PC_ONE;
`endif
        end
        ST_FLUSH: begin
          flush_cnt_d = flush_cnt_q - 3'd1;
          // Last flush cycle: the target read is issued now so that its data
          // lines up with the first RUN cycle.
          if (flush_cnt_q == 3'd1) begin
            pc_issued_d = pc_fetch_q;
            pc_fetch_d  = pc_fetch_q + PC_ONE;
            state_d     = ST_RUN;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  assign out_pmem_addr = pc_fetch_q;
  assign out_pc        = pc_issued_q;
  assign out_flush     = in_jump | (state_q == ST_FLUSH);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. It uses a synchronous PMEM model where each
// word is {4'hA, addr}, which is addr ^ 0xA000 for 12-bit addresses.
// RESET_PC is 0x010 and FLUSH_CYCLES is 2. Inputs change 1 time unit after
// the rising edge. Outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW = 12;
  localparam int WW = 16;
  localparam int PW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_jump = 1'b0;
  logic [PW-1:0] in_jump_target = '0;
  logic          in_stall = 1'b0;
  logic [WW-1:0] in_pmem_data = '0;
  logic [AW-1:0] out_pmem_addr;
  logic [WW-1:0] out_instr;
  logic [PW-1:0] out_pc;
  logic          out_flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Synchronous program memory: data is for the address of the previous cycle.
  always @(posedge clock) in_pmem_data <= {4'hA, out_pmem_addr};

  fetch_unit #(
    .PMEM_ADDR_WIDTH(AW),
    .PMEM_WORD_WIDTH(WW),
    .PC_WIDTH       (PW),
    .RESET_PC       (12'h010),
    .FLUSH_CYCLES   (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_jump       (in_jump),
    .in_jump_target(in_jump_target),
`ifdef FETCH_STALL_EN
    .in_stall      (in_stall),
`endif
    .in_pmem_data  (in_pmem_data),
    .out_pmem_addr (out_pmem_addr),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_flush     (out_flush)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    @(negedge clock);
    n_checks++; if (out_pmem_addr !== 12'h010) begin n_fail++; $display("FAIL reset_addr got %h want 010", out_pmem_addr); end
    n_checks++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", out_instr); end
    n_checks++; if (out_pc !== 12'h010) begin n_fail++; $display("FAIL reset_pc got %h want 010", out_pc); end
    n_checks++; if (out_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", out_flush); end
    reset = 1'b1;
    #1;
    n_checks++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL boot_instr got %h want 0000", out_instr); end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clock);
      n_checks++; if (out_pc !== 12'(12'h010 + i)) begin n_fail++; $display("FAIL run_pc[%0d] got %h want %h", i, out_pc, 12'(12'h010 + i)); end
      n_checks++; if (out_instr !== {4'hA, 12'(12'h010 + i)}) begin n_fail++; $display("FAIL run_instr[%0d] got %h want %h", i, out_instr, {4'hA, 12'(12'h010 + i)}); end
      n_checks++; if (out_flush !== 1'b0) begin n_fail++; $display("FAIL run_flush[%0d] got %b want 0", i, out_flush); end
    end
  endtask

  // Jump to tgt now, then check the flush window and n_run words from tgt.
  task automatic test_jump(input logic [PW-1:0] tgt, input int n_run);
    step();
    in_jump = 1'b1;
    in_jump_target = tgt;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) in_jump = 1'b0;
      @(negedge clock);
      n_checks++; if (out_flush !== 1'b1) begin n_fail++; $display("FAIL jump_flush[T+%0d] got %b want 1", i, out_flush); end
      n_checks++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL jump_instr[T+%0d] got %h want 0000", i, out_instr); end
      step();
    end
    for (int i = 0; i < n_run; i++) begin
      @(negedge clock);
      n_checks++; if (out_pc !== 12'(tgt + i)) begin n_fail++; $display("FAIL jump_pc[%0d] got %h want %h", i, out_pc, 12'(tgt + i)); end
      n_checks++; if (out_instr !== {4'hA, 12'(tgt + i)}) begin n_fail++; $display("FAIL jump_instr_run[%0d] got %h want %h", i, out_instr, {4'hA, 12'(tgt + i)}); end
      n_checks++; if (out_flush !== 1'b0) begin n_fail++; $display("FAIL jump_flush_run[%0d] got %b want 0", i, out_flush); end
      if (i < n_run - 1) step();
    end
  endtask

  task automatic test_double_jump();
    step();
    in_jump = 1'b1;
    in_jump_target = 12'h200;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) in_jump_target = 12'h300;
      if (i == 2) in_jump = 1'b0;
      @(negedge clock);
      n_checks++; if (out_flush !== 1'b1) begin n_fail++; $display("FAIL djump_flush[T+%0d] got %b want 1", i, out_flush); end
      n_checks++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL djump_instr[T+%0d] got %h want 0000", i, out_instr); end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_checks++; if (out_pc !== 12'(12'h300 + i)) begin n_fail++; $display("FAIL djump_pc[%0d] got %h want %h", i, out_pc, 12'(12'h300 + i)); end
      n_checks++; if (out_instr !== {4'hA, 12'(12'h300 + i)}) begin n_fail++; $display("FAIL djump_word[%0d] got %h want %h", i, out_instr, {4'hA, 12'(12'h300 + i)}); end
      if (i == 0) step();
    end
  endtask

  task automatic test_reset_mid_flush();
    step();
    in_jump = 1'b1;
    in_jump_target = 12'h123;
    step();
    in_jump = 1'b0;
    @(negedge clock);
    n_checks++; if (out_flush !== 1'b1) begin n_fail++; $display("FAIL rmf_pre_flush got %b want 1", out_flush); end
    reset = 1'b0;
    step();
    @(negedge clock);
    n_checks++; if (out_flush !== 1'b0) begin n_fail++; $display("FAIL rmf_flush got %b want 0", out_flush); end
    n_checks++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL rmf_instr got %h want 0000", out_instr); end
    n_checks++; if (out_pmem_addr !== 12'h010) begin n_fail++; $display("FAIL rmf_addr got %h want 010", out_pmem_addr); end
    reset = 1'b1;
    step();
    @(negedge clock);
    n_checks++; if (out_pc !== 12'h010) begin n_fail++; $display("FAIL rmf_boot_pc got %h want 010", out_pc); end
    n_checks++; if (out_instr !== 16'hA010) begin n_fail++; $display("FAIL rmf_boot_instr got %h want A010", out_instr); end
  endtask

`ifdef FETCH_STALL_EN
  task automatic test_stall();
    logic [PW-1:0] exp_pc [0:5];
    exp_pc[0] = 12'h005; exp_pc[1] = 12'h005; exp_pc[2] = 12'h005;
    exp_pc[3] = 12'h005; exp_pc[4] = 12'h006; exp_pc[5] = 12'h007;
    test_jump(12'h005, 1);
    // First word of 0x005 is being presented now; stall for three cycles.
    in_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) in_stall = 1'b0;
      @(negedge clock);
      n_checks++; if (out_pc !== exp_pc[i]) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want %h", i, out_pc, exp_pc[i]); end
      n_checks++; if (out_instr !== {4'hA, exp_pc[i]}) begin n_fail++; $display("FAIL stall_instr[%0d] got %h want %h", i, out_instr, {4'hA, exp_pc[i]}); end
      step();
    end
    // Stall and jump together: the jump wins.
    in_stall = 1'b1;
    in_jump = 1'b1;
    in_jump_target = 12'h040;
    @(negedge clock);
    n_checks++; if (out_flush !== 1'b1) begin n_fail++; $display("FAIL stalljump_flush got %b want 1", out_flush); end
    n_checks++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL stalljump_instr got %h want 0000", out_instr); end
    step();
    in_stall = 1'b0;
    in_jump = 1'b0;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_checks++; if (out_pc !== 12'(12'h040 + i)) begin n_fail++; $display("FAIL stalljump_pc[%0d] got %h want %h", i, out_pc, 12'(12'h040 + i)); end
      n_checks++; if (out_instr !== {4'hA, 12'(12'h040 + i)}) begin n_fail++; $display("FAIL stalljump_word[%0d] got %h want %h", i, out_instr, {4'hA, 12'(12'h040 + i)}); end
      if (i == 0) step();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_jump(12'h200, 2);
    test_jump(12'hFFE, 4);
    test_double_jump();
    test_reset_mid_flush();
`ifdef FETCH_STALL_EN
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
